// File: rtl/frame_stack_pkg.sv
// Shared project constants: regfile widths and the register-frame stack sizing.
// Also decodes one cycle's call/ret request into a single stack operation.
package frame_stack_pkg;

  localparam int REG_W    = 32;
  localparam int NUM_REGS = 8;
  localparam int RF_W     = REG_W * NUM_REGS;

  localparam int FRAME_W  = RF_W;
  localparam int DEPTH    = 8;
  localparam int PTR_W    = 4;

  typedef enum logic [2:0] {
    OP_IDLE = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_OVF  = 3'd3,
    OP_UNF  = 3'd4,
    OP_COL  = 3'd5
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic call, input logic ret,
                                          input logic full, input logic empty);
    stack_op_e op;
    case ({call, ret})
      2'b10:   op = full  ? OP_OVF : OP_PUSH;
      2'b01:   op = empty ? OP_UNF : OP_POP;
      2'b11:   op = OP_COL;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/frame_stack_mem.sv
// LIFO frame storage: one synchronous write port, one synchronous read port.
// The array and the read register are deliberately left unreset.
module frame_stack_mem #(
  parameter int FRAME_W = 256,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [FRAME_W-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [FRAME_W-1:0] rdata
);

  logic [FRAME_W-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port; rdata holds until the next read
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/frame_stack.sv
// Register-frame stack: call pushes the regfile frame, ret pops it back with a
// one-cycle restore pulse. Misuse sets sticky overflow/underflow/collision flags.
module frame_stack #(
  parameter int FRAME_W = frame_stack_pkg::FRAME_W,
  parameter int DEPTH   = frame_stack_pkg::DEPTH,
  parameter int PTR_W   = frame_stack_pkg::PTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] frameIn,
  input  logic               call,
  input  logic               ret,
  output logic [FRAME_W-1:0] frameOut,
  output logic               restore,
  output logic [PTR_W-1:0]   depth,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic               underflow,
  output logic               collision
);

  import frame_stack_pkg::*;

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]   sp_r;
  logic [PTR_W-1:0]   sp_m1_s;
  logic               restore_r;
  logic               out_valid_r;
  logic               overflow_r;
  logic               underflow_r;
  logic               collision_r;
  logic               full_s;
  logic               empty_s;
  stack_op_e          op_s;
  logic               push_s;
  logic               pop_s;
  logic               ovf_s;
  logic               unf_s;
  logic               col_s;
  logic [FRAME_W-1:0] rd_data_s;

  assign full_s  = (sp_r == PTR_W'(DEPTH));
  assign empty_s = (sp_r == {PTR_W{1'b0}});
  assign sp_m1_s = sp_r - PTR_W'(1);
  assign op_s    = decode_op(call, ret, full_s, empty_s);

  // One-hot decode of this cycle's stack operation
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    ovf_s  = 1'b0;
    unf_s  = 1'b0;
    col_s  = 1'b0;
    case (op_s)
      OP_PUSH: push_s = 1'b1;
      OP_POP:  pop_s  = 1'b1;
      OP_OVF:  ovf_s  = 1'b1;
      OP_UNF:  unf_s  = 1'b1;
      OP_COL:  col_s  = 1'b1;
      default: push_s = 1'b0;
    endcase
  end

  // Pointer, restore pulse and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_r        <= {PTR_W{1'b0}};
      restore_r   <= 1'b0;
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      collision_r <= 1'b0;
    end else begin
      restore_r <= pop_s;
      if (pop_s) begin
        out_valid_r <= 1'b1;
      end
      if (push_s) begin
        sp_r <= sp_r + PTR_W'(1);
      end else if (pop_s) begin
        sp_r <= sp_m1_s;
      end
      overflow_r  <= overflow_r  | ovf_s;
      underflow_r <= underflow_r | unf_s;
      collision_r <= collision_r | col_s;
    end
  end

  // Writes are suppressed while reset is held so a pending call cannot land.
  frame_stack_mem #(
    .FRAME_W (FRAME_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_s & ~reset),
    .waddr (sp_r[ADDR_W-1:0]),
    .wdata (frameIn),
    .re    (pop_s & ~reset),
    .raddr (sp_m1_s[ADDR_W-1:0]),
    .rdata (rd_data_s)
  );

  assign frameOut  = out_valid_r ? rd_data_s : {FRAME_W{1'b0}};
  assign restore   = restore_r;
  assign depth     = sp_r;
  assign full      = full_s;
  assign empty     = empty_s;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;
  assign collision = collision_r;

endmodule

// File: tb/tb_frame_stack.sv
// Directed bench for frame_stack: fill/drain, interleave, collision, mid-op reset
// and a small behavioural regfile round trip.
module tb_frame_stack;

  localparam int FW = 256;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [FW-1:0] frame_in;
  logic [FW-1:0] frame_drv;
  logic          call;
  logic          ret;
  logic [FW-1:0] frame_out;
  logic          restore;
  logic [PW-1:0] depth;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;
  logic          collision;

  logic          use_rf;
  logic          rf_we;
  logic [FW-1:0] rf_wdata;
  logic [FW-1:0] rf_regs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign frame_in = use_rf ? rf_regs : frame_drv;

  // Behavioural regfile: restore has priority over a normal write
  always @(posedge clk) begin
    if (restore) rf_regs <= frame_out;
    else if (rf_we) rf_regs <= rf_wdata;
  end

  frame_stack dut (
    .clk       (clk),
    .reset     (reset),
    .frameIn   (frame_in),
    .call      (call),
    .ret       (ret),
    .frameOut  (frame_out),
    .restore   (restore),
    .depth     (depth),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow),
    .collision (collision)
  );

  function automatic logic [FW-1:0] mk(input logic [15:0] k);
    return {16{k}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    call = 1'b0; ret = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (depth !== 4'd0) begin n_bad++; $display("FAIL reset_depth got %0d want 0", depth); end
    n_cmp++; if ({empty, full, restore} !== 3'b100) begin n_bad++; $display("FAIL reset_flags got %b want 100", {empty, full, restore}); end
    n_cmp++; if (frame_out !== {FW{1'b0}}) begin n_bad++; $display("FAIL reset_frameOut got %h want 0", frame_out); end
    n_cmp++; if ({overflow, underflow, collision} !== 3'b000) begin n_bad++; $display("FAIL reset_err got %b want 000", {overflow, underflow, collision}); end
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 8; k++) begin
      frame_drv = mk(16'(k)); call = 1'b1;
      step();
      n_cmp++; if (depth !== 4'(k)) begin n_bad++; $display("FAIL fill_depth k=%0d got %0d want %0d", k, depth, k); end
    end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full got %b want 1", full); end
    frame_drv = mk(16'd9);
    step();
    call = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
    n_cmp++; if (depth !== 4'd8) begin n_bad++; $display("FAIL ovf_depth got %0d want 8", depth); end
    n_cmp++; if (restore !== 1'b0) begin n_bad++; $display("FAIL ovf_restore got %b want 0", restore); end
  endtask

  task automatic test_drain();
    ret = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++; if (frame_out !== mk(16'(8 - i))) begin n_bad++; $display("FAIL drain_frame i=%0d got %h want %h", i, frame_out[15:0], 16'(8 - i)); end
      n_cmp++; if (restore !== 1'b1) begin n_bad++; $display("FAIL drain_restore i=%0d got %b want 1", i, restore); end
    end
    n_cmp++; if ({empty, depth} !== {1'b1, 4'd0}) begin n_bad++; $display("FAIL drain_empty got %b/%0d want 1/0", empty, depth); end
    step();
    ret = 1'b0;
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL unf_flag got %b want 1", underflow); end
    n_cmp++; if (restore !== 1'b0) begin n_bad++; $display("FAIL unf_restore got %b want 0", restore); end
    n_cmp++; if (frame_out !== mk(16'd1)) begin n_bad++; $display("FAIL unf_frame got %h want 1", frame_out[15:0]); end
    n_cmp++; if (depth !== 4'd0) begin n_bad++; $display("FAIL unf_depth got %0d want 0", depth); end
  endtask

  task automatic test_interleave();
    do_reset();
    frame_drv = mk(16'hAAAA); call = 1'b1; step();
    frame_drv = mk(16'hBBBB); step();
    call = 1'b0; ret = 1'b1; step();
    ret = 1'b0;
    n_cmp++; if (frame_out !== mk(16'hBBBB)) begin n_bad++; $display("FAIL il_B got %h want bbbb", frame_out[15:0]); end
    frame_drv = mk(16'hCCCC); call = 1'b1; step();
    n_cmp++; if (restore !== 1'b0) begin n_bad++; $display("FAIL il_restore_idle got %b want 0", restore); end
    n_cmp++; if (frame_out !== mk(16'hBBBB)) begin n_bad++; $display("FAIL il_hold got %h want bbbb", frame_out[15:0]); end
    call = 1'b0; ret = 1'b1; step();
    n_cmp++; if (frame_out !== mk(16'hCCCC)) begin n_bad++; $display("FAIL il_C got %h want cccc", frame_out[15:0]); end
    step();
    ret = 1'b0;
    n_cmp++; if (frame_out !== mk(16'hAAAA)) begin n_bad++; $display("FAIL il_A got %h want aaaa", frame_out[15:0]); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL il_empty got %b want 1", empty); end
  endtask

  task automatic test_collision();
    do_reset();
    call = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      frame_drv = mk(16'(k)); step();
    end
    call = 1'b0; ret = 1'b1; step();
    n_cmp++; if ({depth, frame_out[15:0]} !== {4'd2, 16'h0003}) begin n_bad++; $display("FAIL col_setup got %0d/%h want 2/0003", depth, frame_out[15:0]); end
    call = 1'b1; frame_drv = mk(16'h7777); step();
    call = 1'b0; ret = 1'b0;
    n_cmp++; if (depth !== 4'd2) begin n_bad++; $display("FAIL col_depth got %0d want 2", depth); end
    n_cmp++; if (collision !== 1'b1) begin n_bad++; $display("FAIL col_flag got %b want 1", collision); end
    n_cmp++; if (restore !== 1'b0) begin n_bad++; $display("FAIL col_restore got %b want 0", restore); end
    n_cmp++; if (frame_out !== mk(16'd3)) begin n_bad++; $display("FAIL col_frame got %h want 0003", frame_out[15:0]); end
    ret = 1'b1; step();
    ret = 1'b0;
    n_cmp++; if (frame_out !== mk(16'd2)) begin n_bad++; $display("FAIL col_mem got %h want 0002", frame_out[15:0]); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    call = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      frame_drv = mk(16'(k + 4)); step();
    end
    call = 1'b0; ret = 1'b1; step();
    n_cmp++; if ({restore, depth} !== {1'b1, 4'd2}) begin n_bad++; $display("FAIL mr_pre got %b/%0d want 1/2", restore, depth); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({depth, empty, full, restore} !== {4'd0, 3'b100}) begin n_bad++; $display("FAIL mr_async got %0d/%b%b%b want 0/100", depth, empty, full, restore); end
    n_cmp++; if (frame_out !== {FW{1'b0}}) begin n_bad++; $display("FAIL mr_frame got %h want 0", frame_out); end
    n_cmp++; if ({overflow, underflow, collision} !== 3'b000) begin n_bad++; $display("FAIL mr_err got %b want 000", {overflow, underflow, collision}); end
    #1 reset = 1'b0;
    step();
    ret = 1'b0;
    n_cmp++; if ({underflow, restore, depth} !== {2'b10, 4'd0}) begin n_bad++; $display("FAIL mr_unf got %b%b/%0d want 10/0", underflow, restore, depth); end
  endtask

  task automatic test_regfile();
    do_reset();
    use_rf = 1'b1;
    rf_wdata = mk(16'hC0DE); rf_we = 1'b1; step();
    rf_we = 1'b0; call = 1'b1; step();
    call = 1'b0; rf_wdata = mk(16'hBAD0); rf_we = 1'b1; step();
    rf_we = 1'b0;
    n_cmp++; if (rf_regs !== mk(16'hBAD0)) begin n_bad++; $display("FAIL rf_corrupt got %h want bad0", rf_regs[15:0]); end
    ret = 1'b1; step();
    ret = 1'b0;
    n_cmp++; if ({restore, frame_out[15:0]} !== {1'b1, 16'hC0DE}) begin n_bad++; $display("FAIL rf_pop got %b/%h want 1/c0de", restore, frame_out[15:0]); end
    step();
    n_cmp++; if (rf_regs !== mk(16'hC0DE)) begin n_bad++; $display("FAIL rf_restored got %h want c0de", rf_regs[15:0]); end
    use_rf = 1'b0;
  endtask

  initial begin
    reset = 1'b1; call = 1'b0; ret = 1'b0;
    frame_drv = {FW{1'b0}}; use_rf = 1'b0; rf_we = 1'b0; rf_wdata = {FW{1'b0}};
    #2;
    test_reset();
    test_fill();
    test_drain();
    test_interleave();
    test_collision();
    test_mid_reset();
    test_regfile();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
